// File: rtl/ghost_house_scheduler.sv
// ghost_house_scheduler: releases ghosts in index order from per-ghost dot limits, a no-dot
// frame timeout and, when GLOBAL_DOT_EN is defined, a post-death global dot counter.
module ghost_house_scheduler #(
  parameter int NUM_GHOSTS = 4,
  parameter int DOT_CNT_W = 8,
  parameter int TIMEOUT_FRAMES = 240,
  parameter logic [NUM_GHOSTS*DOT_CNT_W-1:0] GLOBAL_LIMITS = {8'd32, 8'd17, 8'd7, 8'd0}
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic                                  restart,
  input  logic                                  life_lost,
  input  logic                                  pause,
  input  logic                                  frame_tick,
  input  logic                                  dot_eaten,
  input  logic [NUM_GHOSTS*DOT_CNT_W-1:0]       dot_limits,
  output logic [NUM_GHOSTS-1:0]                 leave,
  output logic [$clog2(NUM_GHOSTS+1)-1:0]       pref_idx,
  output logic                                  all_released,
  output logic                                  global_mode,
  output logic                                  state_dbg
);

  localparam int PIDX_W = $clog2(NUM_GHOSTS + 1);
  localparam int GI_W = (NUM_GHOSTS > 1) ? $clog2(NUM_GHOSTS) : 1;
  localparam int TMR_W = (TIMEOUT_FRAMES > 1) ? $clog2(TIMEOUT_FRAMES) : 1;
  localparam logic [PIDX_W-1:0] PIDX_LAST = PIDX_W'(NUM_GHOSTS - 1);
  localparam logic [DOT_CNT_W-1:0] CNT_MAX = '1;
  localparam logic [DOT_CNT_W-1:0] GLIMIT_LAST =
    GLOBAL_LIMITS[(NUM_GHOSTS-1)*DOT_CNT_W +: DOT_CNT_W];

  typedef enum logic {S_RUN = 1'b0, S_DONE = 1'b1} state_t;

  state_t                  state, state_nxt;
  logic [PIDX_W-1:0]       pref_q;
  logic [NUM_GHOSTS-1:0]   leave_q;
  logic [DOT_CNT_W-1:0]    cnt_q [NUM_GHOSTS];
  logic [TMR_W-1:0]        timer_q;
  logic [DOT_CNT_W-1:0]    gcnt;
  logic                    gmode;

  logic [GI_W-1:0]         cur;
  logic                    active, dot, tick, timeout_fire;
  logic                    personal_hit, global_hit, release_now, last_release;

  // Release decision, evaluated only on registered counter values.
  always_comb begin
    cur          = pref_q[GI_W-1:0];
    active       = (state == S_RUN) && !pause && !restart;
    dot          = active && dot_eaten;
    tick         = active && frame_tick;
    timeout_fire = tick && (timer_q == TMR_W'(TIMEOUT_FRAMES - 1));
    personal_hit = cnt_q[cur] >= dot_limits[cur*DOT_CNT_W +: DOT_CNT_W];
    global_hit   = gcnt == GLOBAL_LIMITS[cur*DOT_CNT_W +: DOT_CNT_W];
    release_now  = active && ((gmode ? global_hit : personal_hit) || timeout_fire);
    last_release = pref_q == PIDX_LAST;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_RUN;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (restart)                                       state_nxt = S_RUN;
    else if (state == S_RUN && release_now && last_release) state_nxt = S_DONE;
  end

  always_comb begin
    leave        = leave_q;
    pref_idx     = pref_q;
    all_released = (state == S_DONE);
    global_mode  = gmode;
    state_dbg    = state;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pref_q  <= '0;
      leave_q <= '0;
      timer_q <= '0;
    end else if (restart) begin
      pref_q  <= '0;
      leave_q <= '0;
      timer_q <= '0;
    end else begin
      if (release_now) begin
        leave_q[cur] <= 1'b1;
        pref_q       <= pref_q + 1'b1;
      end
      if (dot || timeout_fire) timer_q <= '0;
      else if (tick)           timer_q <= timer_q + 1'b1;
    end
  end

  // A dot on the release cycle still lands on the outgoing ghost because cur is the old index.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_GHOSTS; i++) cnt_q[i] <= '0;
    end else if (restart) begin
      if (!life_lost) begin
        for (int i = 0; i < NUM_GHOSTS; i++) cnt_q[i] <= '0;
      end
    end else if (dot && !gmode && cnt_q[cur] != CNT_MAX) begin
      cnt_q[cur] <= cnt_q[cur] + 1'b1;
    end
  end

`ifdef GLOBAL_DOT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gcnt  <= '0;
      gmode <= 1'b0;
    end else if (restart) begin
      gcnt  <= '0;
      gmode <= life_lost;
    end else begin
      if (dot && gmode && gcnt != CNT_MAX) gcnt <= gcnt + 1'b1;
      // Reaching the last threshold hands control back to the personal counters.
      if (active && gmode && gcnt == GLIMIT_LAST) gmode <= 1'b0;
      if (release_now && last_release)            gmode <= 1'b0;
    end
  end
`else
  assign gcnt  = '0;
  assign gmode = 1'b0;
`endif

endmodule
